// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: requester count,
// default watchdog length and the FSM state encoding.
package uart_pkg;

  localparam int NUM_REQ                = 4;
  localparam int IDX_W                  = $clog2(NUM_REQ);
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection over NUM_REQ requesters. The search starts one
// past the last granted index; the pointer moves only when a grant is taken.
module rr_arbiter
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_cand  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_grant = '0;
    // Index arithmetic wraps modulo NUM_REQ; k=NUM_REQ revisits the last winner.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = r_last_grant + IDX_W'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found) begin
      w_grant = NUM_REQ'(1) << w_idx;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (i_advance) begin
      r_last_grant <= w_idx;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources: grants in IDLE,
// strobes the byte for one cycle in ISSUE, then waits for tx_done or a watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [IDX_W-1:0]     owner,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_tx_data_valid;
  logic [7:0]         r_tx_data;
  logic [IDX_W-1:0]   r_owner;
  logic               r_busy;
  logic               r_timeout_err;

  logic               w_can_grant;
  logic               w_transfer;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [CNT_W-1:0]   w_wait_cnt_next;
  logic               w_timeout;

  // The transmitter survives our reset, so tx_active alone gates new grants.
  assign w_can_grant     = (r_state == ST_IDLE) && !tx_active;
  assign w_transfer      = w_can_grant && (|req_valid);
  assign w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
  assign w_timeout       = (w_wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  rr_arbiter u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req_valid),
    .i_advance   (w_transfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign req_ready = w_can_grant ? w_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wait_cnt      <= '0;
      r_tx_data_valid <= 1'b0;
      r_tx_data       <= '0;
      r_owner         <= '0;
      r_busy          <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_transfer) begin
            r_tx_data       <= req_data[{w_grant_idx, 3'b000} +: 8];
            r_owner         <= w_grant_idx;
            r_tx_data_valid <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tx_data_valid <= 1'b0;
          r_wait_cnt      <= '0;
          r_state         <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          r_wait_cnt <= w_wait_cnt_next;
          // A completion in the same cycle as expiry is a normal finish.
          if (tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_tx_data_valid <= 1'b0;
          r_busy          <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data_valid = r_tx_data_valid;
  assign tx_data       = r_tx_data;
  assign owner         = r_owner;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles in WAIT_DONE before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  4  per-requester byte-pending flag.
REQ-005 SHALL have port req_data  input  32  requester i byte at bits [8i+7:8i].
REQ-006 SHALL have port req_ready  output  4  one-hot accept strobe to the granted requester.
REQ-007 SHALL have port tx_data_valid  output  1  start strobe to the UART transmitter.
REQ-008 SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-009 SHALL have port tx_active  input  1  transmitter busy flag.
REQ-010 SHALL have port tx_done  input  1  transmitter end-of-stop-bit pulse.
REQ-011 SHALL have port owner  output  2  index of the requester whose byte is in flight.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_DONE.
REQ-015 In IDLE with tx_active=0 and any req_valid set, SHALL drive req_ready one-hot to the round-robin winner combinationally; transfer occurs on that edge.
REQ-016 Round-robin SHALL search from (last_grant+1) mod 4 upward, wrapping 3->0; last_grant SHALL update only on a transfer.
REQ-017 On transfer SHALL latch the winner's byte into tx_data and its index into owner, then go to ISSUE.
REQ-018 req_ready SHALL be all-zero outside IDLE or while tx_active=1.
REQ-019 ISSUE SHALL last exactly one cycle with tx_data_valid=1, then go to WAIT_DONE.
REQ-020 tx_data_valid SHALL be 0 in every state except ISSUE.
REQ-021 tx_data and owner SHALL hold stable from the transfer until the next transfer.
REQ-022 WAIT_DONE SHALL return to IDLE on tx_done=1; the next grant can occur in the following cycle.
REQ-023 WAIT_DONE SHALL count cycles in a counter of width clog2(TIMEOUT_CYCLES+1), cleared on entry; on reaching TIMEOUT_CYCLES SHALL pulse timeout_err and return to IDLE.
REQ-024 tx_done and timeout in the same cycle: tx_done wins, with no timeout_err.
REQ-025 tx_done received in IDLE or ISSUE SHALL be ignored.
REQ-026 A requester SHALL NOT be starved: each pending requester is served within 4 grants.

Reset
REQ-027 On rst: state=IDLE, last_grant=3 (so requester 0 wins first), req_ready=0, tx_data_valid=0, tx_data=0, owner=0, busy=0, timeout_err=0, counter=0.
REQ-028 Reset mid-frame SHALL abort immediately; no new grant SHALL occur until tx_active=0, because the transmitter has no reset.

Structure
REQ-029 State encoding, NUM_REQ=4 and the default TIMEOUT_CYCLES SHALL live in shared package uart_pkg.
REQ-030 Winner selection and pointer update SHALL be a sub-module rr_arbiter (4-bit request in, one-hot grant plus 2-bit index out).

Verification
REQ-031 Single request: req_valid=0001, req_data[7:0]=0xA5 -> req_ready=0001 for 1 cycle, tx_data_valid pulse next cycle with tx_data=0xA5 and owner=0.
REQ-032 All four pending at reset -> grant order 0,1,2,3,0, each grant following the prior tx_done by 1 cycle.
REQ-033 tx_active=1 held with req_valid=0010 -> req_ready stays 0; it asserts on the first cycle tx_active=0.
REQ-034 tx_done withheld with TIMEOUT_CYCLES=16 -> timeout_err pulses after 16 WAIT_DONE cycles, state=IDLE, busy=0.
REQ-035 tx_done and timeout coincide -> no timeout_err; normal return to IDLE.
REQ-036 rst asserted during WAIT_DONE -> all outputs at reset values asynchronously; the stray later tx_done is ignored.
